even_parity_serial_chk: RTL

//  Downstream consumer of the even-parity generator stage. Receives a serial frame
//  (start, DATA_W data bits LSB first, even-parity bit, stop) one bit per qualified

---
 rtl/even_parity_serial_chk.sv | 112 +++++++++++
 1 files changed

// File: rtl/even_parity_serial_chk.sv
// even_parity_serial_chk
//   Serial receiver and checker for frames made by the even-parity generator stage.
//   Frame layout on the line, one bit per qualified clock:
//     start (0), DATA_W data bits LSB first, even-parity bit, stop (1).
//   The block rebuilds the data word, checks parity and framing, and reports the
//   result with a one-cycle strobe. A saturating counter tracks frames with bad parity.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous reset, active-high
//   sin       in   serial line, idles at 1
//   sin_vld   in   sin is sampled only when high; otherwise all state holds
//   dout      out  last received data word (bit 0 = first data bit)
//   dout_vld  out  one-cycle pulse when dout/par_err/frm_err are updated
//   par_err   out  parity of data plus parity bit was odd for the last frame
//   frm_err   out  stop bit was sampled as 0 for the last frame
//   busy      out  receiver is inside a frame (state is not idle)
//   err_cnt   out  number of frames with par_err, saturates at all-ones

module even_parity_serial_chk #(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  input  logic              sin_vld,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              par_err,
  output logic              frm_err,
  output logic              busy,
  output logic [CNT_W-1:0]  err_cnt
);

  // Bit index counter needs at least one bit even for a single-bit data word.
  localparam int unsigned          BitCntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BitCntW-1:0]   LastBit = BitCntW'(DATA_W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StPar,
    StStop
  } state_e;

  state_e              state_q;
  logic [BitCntW-1:0]  cnt_q;
  logic [DATA_W-1:0]   shreg_q;
  logic                par_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      dout     <= '0;
      dout_vld <= 1'b0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
      err_cnt  <= '0;
    end else begin
      // The strobe always drops after one cycle, even while the line is unqualified.
      dout_vld <= 1'b0;
      if (sin_vld) begin
        unique case (state_q)
          StIdle: begin
            if (!sin) begin
              state_q <= StData;
              cnt_q   <= '0;
              par_q   <= 1'b0;
            end
          end
          StData: begin
            for (int unsigned i = 0; i < DATA_W; i++) begin
              if (cnt_q == BitCntW'(i)) begin
                shreg_q[i] <= sin;
              end
            end
            par_q <= par_q ^ sin;
            if (cnt_q == LastBit) begin
              state_q <= StPar;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StPar: begin
            // After this, par_q is 1 exactly when data plus parity bit is odd.
            par_q   <= par_q ^ sin;
            state_q <= StStop;
          end
          StStop: begin
            // A bad stop bit still completes the frame; it is only flagged.
            state_q  <= StIdle;
            dout     <= shreg_q;
            par_err  <= par_q;
            frm_err  <= ~sin;
            dout_vld <= 1'b1;
            if (par_q && (err_cnt != '1)) begin
              err_cnt <= err_cnt + 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign busy = (state_q != StIdle);

endmodule
